// File: rtl/test_pkg.sv
// Shared helpers for the capture arbiter: channel-tag width and FIFO entry width.
package test_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(n)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // A FIFO entry is {channel tag, sample}.
    function automatic int entry_width(input int ch, input int w);
        return clog2_min1(ch) + w;
    endfunction

endpackage

// File: rtl/test_sync_fifo.sv
// Generic show-ahead FIFO with MSB-extended pointers and an occupancy output.
module test_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_pop_s;
    logic         do_push_s;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level     = wptr_q - rptr_q;
    assign rdata     = mem_q[rptr_q[AW-1:0]];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Next-state for pointers and storage.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/test_capture_arb.sv
// Multi-channel sample capture: per-channel pending registers, round-robin
// arbitration into a shared show-ahead FIFO, sticky overrun flags.
module test_capture_arb
    import test_pkg::*;
#(
    parameter int CH    = 3,
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int CHW  = clog2_min1(CH),
    localparam int LW   = $clog2(DEPTH) + 1,
    localparam int EW   = entry_width(CH, W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [W-1:0]    out_data,
    output logic [CHW-1:0]  out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LW-1:0]   level,
    output logic [CH-1:0]   drop,
    input  logic            drop_clr
);

    logic [CH-1:0]  pend_q, pend_d;
    logic [W-1:0]   data_q [CH];
    logic [W-1:0]   data_d [CH];
    logic [CH-1:0]  drop_q, drop_d;
    logic [CHW-1:0] last_q, last_d;

    logic           gnt_vld_s;
    logic [CHW-1:0] gnt_idx_s;
    logic [CHW-1:0] cand_s;
    logic           can_push_s;
    logic           empty_s;
    logic           full_s;
    logic [EW-1:0]  wdata_s;
    logic [EW-1:0]  rdata_s;

    // A slot frees up in the same cycle if the consumer takes the head.
    assign can_push_s = !full_s || (!empty_s && out_ready);
    assign wdata_s    = {gnt_idx_s, data_q[gnt_idx_s]};

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int i = 1; i <= CH; i++) begin
            cand_s = CHW'((int'(last_q) + i) % CH);
            if (!gnt_vld_s && pend_q[cand_s] && can_push_s) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = cand_s;
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // Pending registers, overrun detection and last-grant pointer.
    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        drop_d = drop_q;
        for (int k = 0; k < CH; k++) begin
            if (in_valid[k]) begin
                pend_d[k] = 1'b1;
                data_d[k] = in_data[k*W +: W];
            end else if (gnt_vld_s && (gnt_idx_s == CHW'(k))) begin
                pend_d[k] = 1'b0;
            end else begin
                pend_d[k] = pend_q[k];
            end
            // A reload in the grant cycle is not an overrun; set beats clear.
            if (in_valid[k] && pend_q[k] && !(gnt_vld_s && (gnt_idx_s == CHW'(k)))) begin
                drop_d[k] = 1'b1;
            end else if (drop_clr) begin
                drop_d[k] = 1'b0;
            end else begin
                drop_d[k] = drop_q[k];
            end
        end
        if (gnt_vld_s) begin
            last_d = gnt_idx_s;
        end else begin
            last_d = last_q;
        end
    end

    // State registers; last grant resets to CH-1 so channel 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            drop_q <= '0;
            last_q <= CHW'(CH - 1);
            for (int k = 0; k < CH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

    test_sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_vld_s),
        .wdata (wdata_s),
        .pop   (out_ready),
        .rdata (rdata_s),
        .empty (empty_s),
        .full  (full_s),
        .level (level)
    );

    assign out_data  = rdata_s[W-1:0];
    assign out_ch    = rdata_s[EW-1:W];
    assign out_valid = !empty_s;
    assign drop      = drop_q;

endmodule

// File: tb/tb_test_capture_arb.sv
// Directed self-checking bench for test_capture_arb (CH=3, W=4, DEPTH=8).
module tb_test_capture_arb;

    localparam int CH    = 3;
    localparam int W     = 4;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [W-1:0]    out_data;
    logic [1:0]      out_ch;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      level;
    logic [CH-1:0]   drop;
    logic            drop_clr;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    test_capture_arb #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .drop      (drop),
        .drop_clr  (drop_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] ech;
        logic [3:0] ed;
        rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0; drop_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);

        // Single sample on channel 1: visible two edges later.
        in_valid = 3'b010; in_data = 12'h0A0;
        tick();
        in_valid = 3'b000;
        chk("single_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_ch", 32'(out_ch), 32'd1);
        chk("single_data", 32'(out_data), 32'hA);
        chk("single_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_level", 32'(level), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);

        // Round-robin from reset: channel order 0,1,2.
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 3'b111; in_data = 12'h321; out_ready = 1'b1;
        tick();
        in_valid = 3'b000;
        tick();
        chk("rr0_ch", 32'(out_ch), 32'd0);
        chk("rr0_data", 32'(out_data), 32'h1);
        chk("rr0_level", 32'(level), 32'd1);
        tick();
        chk("rr1_ch", 32'(out_ch), 32'd1);
        chk("rr1_data", 32'(out_data), 32'h2);
        tick();
        chk("rr2_ch", 32'(out_ch), 32'd2);
        chk("rr2_data", 32'(out_data), 32'h3);
        tick();
        chk("rr_empty", 32'(out_valid), 32'd0);
        chk("rr_level", 32'(level), 32'd0);
        chk("rr_drop", 32'(drop), 32'd0);

        // Fill: channel 0 strobes 0..8, consumer stalled.
        out_ready = 1'b0;
        for (int n = 0; n <= 8; n++) begin
            in_valid = 3'b001; in_data = '0; in_data[3:0] = 4'(n);
            tick();
        end
        in_valid = 3'b000;
        chk("full_level", 32'(level), 32'd8);
        chk("full_head_data", 32'(out_data), 32'h0);
        chk("full_head_ch", 32'(out_ch), 32'd0);
        tick(); tick();
        chk("full_hold_level", 32'(level), 32'd8);
        chk("full_hold_drop", 32'(drop), 32'd0);

        // Overrun on channel 2 while full; drop_clr vs simultaneous set.
        in_valid = 3'b100; in_data = 12'h500;
        tick();
        chk("ovr_first_nodrop", 32'(drop), 32'd0);
        in_data = 12'h600;
        tick();
        in_valid = 3'b000;
        chk("ovr_drop_set", 32'(drop), 32'b100);
        tick();
        chk("ovr_drop_sticky", 32'(drop), 32'b100);
        drop_clr = 1'b1;
        tick();
        chk("ovr_drop_clr", 32'(drop), 32'd0);
        in_valid = 3'b100; in_data = 12'h700;
        tick();
        in_valid = 3'b000;
        chk("ovr_set_wins", 32'(drop), 32'b100);
        tick();
        drop_clr = 1'b0;
        chk("ovr_clr_again", 32'(drop), 32'd0);

        // Push and pop together at full: channel 2 (data 7) accepted.
        out_ready = 1'b1;
        tick();
        chk("pp_level", 32'(level), 32'd8);
        chk("pp_head_data", 32'(out_data), 32'h1);
        chk("pp_head_ch", 32'(out_ch), 32'd0);

        // Continuous channel-1 strobes while draining: pointer wrap, order kept.
        for (int j = 1; j <= 20; j++) begin
            in_valid = 3'b010; in_data = '0; in_data[7:4] = 4'(8 + j);
            tick();
            if (j <= 6) begin
                ech = 2'd0; ed = 4'(j + 1);
            end else if (j == 7) begin
                ech = 2'd2; ed = 4'd7;
            end else if (j == 8) begin
                ech = 2'd0; ed = 4'd8;
            end else begin
                ech = 2'd1; ed = 4'(j);
            end
            chk($sformatf("wrap%0d_ch", j), 32'(out_ch), 32'(ech));
            chk($sformatf("wrap%0d_data", j), 32'(out_data), 32'(ed));
            chk($sformatf("wrap%0d_level", j), 32'(level), 32'd8);
        end
        in_valid = 3'b000; out_ready = 1'b0;

        // Reset mid-stream with level 5 and all channels pending.
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 3'b111; in_data = 12'h321;
        tick();
        in_valid = 3'b000;
        tick(); tick();
        in_valid = 3'b111;
        tick();
        in_valid = 3'b000;
        tick();
        in_valid = 3'b111;
        tick();
        in_valid = 3'b000;
        chk("pre_rst_level", 32'(level), 32'd5);
        chk("pre_rst_drop", 32'(drop), 32'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_drop", 32'(drop), 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
